// File: rtl/udp_decoder_pkg.sv
// Shared constants, FSM encoding and helpers for the UDP receive path.
package udp_decoder_pkg;

   localparam logic [15:0] UDP_HDR_LEN = 16'd8;
   localparam logic [15:0] UDP_PROTO   = 16'h0011;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      HDR1    = 2'd1,
      PAYLOAD = 2'd2,
      DONE    = 2'd3
   } udp_state_t;

   // Byte-valid mask for the final payload word: rem MSB bytes kept
   function automatic logic [3:0] keep_mask(input logic [15:0] rem);
      case (rem)
         16'd1:   return 4'b1000;
         16'd2:   return 4'b1100;
         16'd3:   return 4'b1110;
         default: return 4'b1111;
      endcase
   endfunction

   // One's-complement fold 32 -> 17 -> 16 bits
   function automatic logic [15:0] csum_fold(input logic [31:0] acc);
      logic [16:0] s17;
      s17 = {1'b0, acc[31:16]} + {1'b0, acc[15:0]};
      return s17[15:0] + {15'd0, s17[16]};
   endfunction

endpackage

// File: rtl/udp_csum_acc.sv
// One's-complement checksum accumulator: clear/add of two masked 16-bit
// halves plus an extra pre-summed term. sum16_nxt is the folded value the
// accumulator takes at the coming edge, so a registered verdict can be
// produced in the same cycle as the last add.
module udp_csum_acc
   import udp_decoder_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        clr,
   input  logic        en,
   input  logic [31:0] word,
   input  logic [3:0]  keep,
   input  logic [31:0] extra,
   output logic [15:0] sum16_nxt
);

   logic [31:0] acc;
   logic [31:0] masked;
   logic [31:0] acc_nxt;

   // Mask dropped bytes and form the next accumulator value
   always_comb begin
      masked  = word & {{8{keep[3]}}, {8{keep[2]}}, {8{keep[1]}}, {8{keep[0]}}};
      acc_nxt = acc;
      if (en)
         acc_nxt = (clr ? 32'd0 : acc) + {16'd0, masked[31:16]} +
                   {16'd0, masked[15:0]} + extra;
   end

   assign sum16_nxt = csum_fold(acc_nxt);

   // Accumulator register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) acc <= 32'd0;
      else        acc <= acc_nxt;
   end

endmodule

// File: rtl/udp_decoder.sv
// UDP receive-side decoder: parses header words, forwards payload words
// with byte-valid masks and checks the checksum incl. the pseudo-header.
module udp_decoder
   import udp_decoder_pkg::*;
#(
   parameter logic [15:0] MAX_LEN = 16'd1480
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] src_ip,
   input  logic [31:0] dest_ip,
   input  logic [31:0] data,
   input  logic        data_av,
   input  logic        start,
   output logic [15:0] src_port,
   output logic [15:0] dest_port,
   output logic [15:0] len_out,
   output logic [31:0] pkg_data,
   output logic [3:0]  keep,
   output logic        wr_en,
   output logic        fin,
   output logic        chksum_ok,
   output logic        len_err
);

   udp_state_t  state;
   logic [15:0] rem;
   logic [15:0] rx_csum;
   logic [15:0] w_len;
   logic        take_start, take_hdr, take_pay;
   logic        pay_last, len_bad;
   logic        acc_clr, acc_en;
   logic [3:0]  acc_keep;
   logic [31:0] acc_extra;
   logic [15:0] sum16_nxt;

   assign w_len      = data[31:16];
   assign take_start = data_av & start;
   assign take_hdr   = data_av & ~start & (state == HDR1);
   assign take_pay   = data_av & ~start & (state == PAYLOAD);
   assign pay_last   = (rem <= 16'd4);
   assign len_bad    = (w_len < UDP_HDR_LEN) || (w_len > MAX_LEN);

   // Accumulator operand select: pseudo-header seed on w0, length again on w1
   always_comb begin
      acc_clr   = take_start;
      acc_en    = take_start | take_hdr | take_pay;
      acc_keep  = 4'b1111;
      acc_extra = 32'd0;
      if (take_start)
         acc_extra = {16'd0, src_ip[31:16]} + {16'd0, src_ip[15:0]} +
                     {16'd0, dest_ip[31:16]} + {16'd0, dest_ip[15:0]} +
                     {16'd0, UDP_PROTO};
      else if (take_hdr)
         acc_extra = {16'd0, w_len};
      else if (take_pay && pay_last)
         acc_keep = keep_mask(rem);
   end

   udp_csum_acc u_acc (
      .clk       (clk),
      .reset     (reset),
      .clr       (acc_clr),
      .en        (acc_en),
      .word      (data),
      .keep      (acc_keep),
      .extra     (acc_extra),
      .sum16_nxt (sum16_nxt)
   );

   // Main FSM with registered outputs; fin is raised on the edge entering DONE
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         rem       <= 16'd0;
         rx_csum   <= 16'd0;
         src_port  <= 16'd0;
         dest_port <= 16'd0;
         len_out   <= 16'd0;
         pkg_data  <= 32'd0;
         keep      <= 4'd0;
         wr_en     <= 1'b0;
         fin       <= 1'b0;
         chksum_ok <= 1'b0;
         len_err   <= 1'b0;
      end else begin
         wr_en     <= 1'b0;
         fin       <= 1'b0;
         chksum_ok <= 1'b0;
         len_err   <= 1'b0;
         if (take_start) begin
            // new datagram wins over whatever was in progress
            src_port  <= data[31:16];
            dest_port <= data[15:0];
            state     <= HDR1;
         end else begin
            case (state)
               IDLE: ;
               HDR1: if (take_hdr) begin
                  len_out <= w_len;
                  rx_csum <= data[15:0];
                  if (len_bad) begin
                     state   <= DONE;
                     fin     <= 1'b1;
                     len_err <= 1'b1;
                  end else if (w_len == UDP_HDR_LEN) begin
                     state     <= DONE;
                     fin       <= 1'b1;
                     chksum_ok <= (data[15:0] == 16'h0000) | (sum16_nxt == 16'hFFFF);
                  end else begin
                     rem   <= w_len - UDP_HDR_LEN;
                     state <= PAYLOAD;
                  end
               end
               PAYLOAD: if (take_pay) begin
                  pkg_data <= data;
                  keep     <= acc_keep;
                  wr_en    <= 1'b1;
                  rem      <= pay_last ? 16'd0 : rem - 16'd4;
                  if (pay_last) begin
                     state     <= DONE;
                     fin       <= 1'b1;
                     chksum_ok <= (rx_csum == 16'h0000) | (sum16_nxt == 16'hFFFF);
                  end
               end
               DONE: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_udp_decoder.sv
// Self-checking bench for udp_decoder: directed datagrams plus randomized
// ones checked against a byte-level checksum/packing model.
module tb_udp_decoder;

   localparam logic [15:0] MAX_LEN = 16'd1480;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] src_ip, dest_ip, data;
   logic        data_av, start;
   logic [15:0] src_port, dest_port, len_out;
   logic [31:0] pkg_data;
   logic [3:0]  keep;
   logic        wr_en, fin, chksum_ok, len_err;

   udp_decoder #(.MAX_LEN(MAX_LEN)) dut (
      .clk       (clk),
      .reset     (reset),
      .src_ip    (src_ip),
      .dest_ip   (dest_ip),
      .data      (data),
      .data_av   (data_av),
      .start     (start),
      .src_port  (src_port),
      .dest_port (dest_port),
      .len_out   (len_out),
      .pkg_data  (pkg_data),
      .keep      (keep),
      .wr_en     (wr_en),
      .fin       (fin),
      .chksum_ok (chksum_ok),
      .len_err   (len_err)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // ---------------- monitor ----------------
   logic [35:0] got_wr[$];
   int          fin_cnt = 0;
   int          cyc = 0;
   int          fin_cyc = 0;
   logic [15:0] f_sp, f_dp, f_len;
   logic        f_ok, f_lerr;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (wr_en) got_wr.push_back({keep, pkg_data});
      if (fin) begin
         fin_cnt <= fin_cnt + 1;
         fin_cyc <= cyc;
         f_sp    <= src_port;
         f_dp    <= dest_port;
         f_len   <= len_out;
         f_ok    <= chksum_ok;
         f_lerr  <= len_err;
      end
   end

   // ---------------- reference model ----------------
   logic [31:0] tx_words[$];
   logic [35:0] exp_wr[$];
   logic        exp_ok, exp_lerr;
   logic [15:0] exp_sp, exp_dp, exp_len;
   int          last_cyc = 0;

   function automatic logic [15:0] ofold(input longint s);
      longint t;
      t = s;
      while (t > 64'hFFFF) t = (t & 64'hFFFF) + (t >> 16);
      return t[15:0];
   endfunction

   // Build a datagram as a byte string; mode 0 = good checksum, 1 = none, 2 = corrupted
   task automatic build_pkt(input logic [15:0] sp, input logic [15:0] dp,
                            input logic [15:0] len, input int mode);
      byte unsigned b[];
      int           n;
      longint       s;
      logic [15:0]  cs;
      logic [31:0]  w;
      logic [3:0]   k;
      tx_words.delete();
      exp_wr.delete();
      exp_sp   = sp;
      exp_dp   = dp;
      exp_len  = len;
      exp_lerr = (len < 16'd8) || (len > MAX_LEN);
      if (exp_lerr) begin
         exp_ok = 1'b0;
         tx_words.push_back({sp, dp});
         tx_words.push_back({len, 16'($urandom)});
         return;
      end
      n = int'(len);
      b = new[n + 4];
      foreach (b[i]) b[i] = (i < n) ? 8'($urandom) : 8'h00;
      b[0] = sp[15:8];  b[1] = sp[7:0];
      b[2] = dp[15:8];  b[3] = dp[7:0];
      b[4] = len[15:8]; b[5] = len[7:0];
      b[6] = 8'h00;     b[7] = 8'h00;
      s = longint'(src_ip[31:16]) + longint'(src_ip[15:0]) +
          longint'(dest_ip[31:16]) + longint'(dest_ip[15:0]) + 64'd17 + longint'(len);
      for (int i = 0; i < n; i += 2) s += longint'({b[i], b[i+1]});
      cs = ~ofold(s);
      if (cs == 16'h0000) cs = 16'hFFFF;
      if (mode == 1) cs = 16'h0000;
      if (mode == 2) cs = cs ^ 16'h0100;
      b[6] = cs[15:8];
      b[7] = cs[7:0];
      exp_ok = (cs == 16'h0000) || (ofold(s + longint'(cs)) == 16'hFFFF);
      for (int i = 0; i < n; i += 4) begin
         w = {b[i], b[i+1], b[i+2], b[i+3]};
         tx_words.push_back(w);
         if (i >= 8) begin
            for (int j = 0; j < 4; j++) k[3-j] = (i + j < n);
            exp_wr.push_back({k, w});
         end
      end
   endtask

   task automatic load_t1(input logic [31:0] w1, input logic ok);
      src_ip   = 32'd1;
      dest_ip  = 32'd2;
      tx_words = '{32'ha08f2694, w1, 32'h48656c6c, 32'h6f20576f, 32'h726c6400};
      exp_wr   = '{{4'hf, 32'h48656c6c}, {4'hf, 32'h6f20576f}, {4'he, 32'h726c6400}};
      exp_sp   = 16'ha08f;
      exp_dp   = 16'h2694;
      exp_len  = 16'h0013;
      exp_ok   = ok;
      exp_lerr = 1'b0;
   endtask

   // ---------------- driver ----------------
   task automatic send(input int nw, input int gmin, input int gmax);
      for (int i = 0; i < nw; i++) begin
         repeat ($urandom_range(gmax, gmin)) begin
            @(posedge clk); #1;
         end
         data    = tx_words[i];
         data_av = 1'b1;
         start   = (i == 0);
         @(posedge clk); #1;
         data_av  = 1'b0;
         start    = 1'b0;
         data     = $urandom;
         last_cyc = cyc;
      end
   endtask

   task automatic run_check(input string nm, input int fin0);
      repeat (3) begin
         @(posedge clk); #1;
      end
      chk({nm, ".fin_count"}, 64'(fin_cnt - fin0), 64'd1);
      if (fin_cnt - fin0 == 1) begin
         chk({nm, ".fin_latency"}, 64'(fin_cyc), 64'(last_cyc));
         chk({nm, ".src_port"}, f_sp, exp_sp);
         chk({nm, ".dest_port"}, f_dp, exp_dp);
         chk({nm, ".len_out"}, f_len, exp_len);
         chk({nm, ".chksum_ok"}, f_ok, exp_ok);
         chk({nm, ".len_err"}, f_lerr, exp_lerr);
      end
      chk({nm, ".wr_count"}, 64'(got_wr.size()), 64'(exp_wr.size()));
      for (int i = 0; i < got_wr.size() && i < exp_wr.size(); i++)
         chk({nm, ".wr_word"}, got_wr[i], exp_wr[i]);
      got_wr.delete();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int          f0;
      logic [35:0] a0, a1;
      logic [15:0] len;
      int          r;
      reset   = 1'b0;
      data    = 32'd0;
      data_av = 1'b0;
      start   = 1'b0;
      src_ip  = 32'd0;
      dest_ip = 32'd0;
      repeat (3) begin
         @(posedge clk); #1;
      end
      chk("reset.hdr", {src_port, dest_port, len_out}, 64'd0);
      chk("reset.out", {pkg_data, keep, wr_en, fin, chksum_ok, len_err}, 64'd0);
      reset = 1'b1;
      @(posedge clk); #1;

      // T1 / T2: Hello World with good, absent and wrong checksum
      load_t1(32'h0013e6d3, 1'b1); f0 = fin_cnt; send(5, 0, 0); run_check("t1", f0);
      load_t1(32'h00130000, 1'b1); f0 = fin_cnt; send(5, 0, 0); run_check("t2_nocs", f0);
      load_t1(32'h0013e6d4, 1'b0); f0 = fin_cnt; send(5, 0, 0); run_check("t2_bad", f0);
      // T3: gaps between every word
      load_t1(32'h0013e6d3, 1'b1); f0 = fin_cnt; send(5, 1, 3); run_check("t3_gaps", f0);

      // T4: header-only and bad lengths, plus the MAX_LEN boundary
      src_ip = $urandom; dest_ip = $urandom;
      build_pkt(16'h1111, 16'h2222, 16'd8, 0); f0 = fin_cnt; send(tx_words.size(), 0, 1); run_check("t4_len8", f0);
      build_pkt(16'h1111, 16'h2222, 16'd5, 0); f0 = fin_cnt; send(tx_words.size(), 0, 1); run_check("t4_len5", f0);
      build_pkt(16'h3333, 16'h4444, MAX_LEN, 0); f0 = fin_cnt; send(tx_words.size(), 0, 0); run_check("t4_max", f0);
      build_pkt(16'h3333, 16'h4444, MAX_LEN + 16'd1, 0); f0 = fin_cnt; send(tx_words.size(), 0, 0); run_check("t4_max1", f0);

      // T5: abort at w3, then a full datagram; the partial payload writes still appear
      load_t1(32'h0013e6d3, 1'b1);
      a0 = exp_wr[0];
      a1 = exp_wr[1];
      f0 = fin_cnt;
      send(4, 0, 1);
      send(5, 0, 1);
      exp_wr.push_front(a1);
      exp_wr.push_front(a0);
      run_check("t5_abort", f0);

      // T6: reset mid-datagram, then a clean datagram
      load_t1(32'h0013e6d3, 1'b1);
      f0 = fin_cnt;
      send(3, 0, 0);
      reset = 1'b0;
      #2;
      chk("t6_rst.hdr", {src_port, dest_port, len_out}, 64'd0);
      chk("t6_rst.out", {pkg_data, keep, wr_en, fin, chksum_ok, len_err}, 64'd0);
      repeat (3) begin
         @(posedge clk); #1;
      end
      reset = 1'b1;
      got_wr.delete();
      send(5, 0, 2);
      run_check("t6_after", f0);

      // Randomized datagrams
      for (int p = 0; p < 40; p++) begin
         src_ip  = $urandom;
         dest_ip = $urandom;
         r = $urandom_range(99);
         if (r < 8)       len = 16'($urandom_range(7));
         else if (r < 12) len = MAX_LEN + 16'd1 + 16'($urandom_range(100));
         else             len = 16'd8 + 16'($urandom_range(60));
         build_pkt(16'($urandom), 16'($urandom), len, int'($urandom_range(2)));
         f0 = fin_cnt;
         send(tx_words.size(), 0, 2);
         run_check("rand", f0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
